// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port
// among NUM_REQ writeback sources, with a registered write stage.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      we3,
   output logic [ADDR_W-1:0]         wa3,
   output logic [DATA_W-1:0]         wd3,
   output logic [ID_W-1:0]           grant_id
);

   logic [ID_W-1:0]   ptr;
   logic              found;
   logic [ID_W-1:0]   grant_idx;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              xfer;

   // Index k positions past p, wrapped into 0..NUM_REQ-1.
   function automatic logic [ID_W-1:0] wrap_idx(
      input logic [ID_W-1:0] p,
      input int              k
   );
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end
      return ID_W'(s);
   endfunction

   // Round-robin search starting one past the last winner.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[wrap_idx(ptr, k)]) begin
            found     = 1'b1;
            grant_idx = wrap_idx(ptr, k);
         end
      end
   end

   // Ready is one-hot on the winner; stall or reset grants nothing.
   always_comb begin
      req_ready = '0;
      if (enable && !reset && found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign xfer = |(req_valid & req_ready);

   // Steer the winning requester's address and data to the write stage.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Register the accepted write; x0 targets complete but never assert we3.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr      <= ID_W'(NUM_REQ - 1);
         we3      <= 1'b0;
         wa3      <= '0;
         wd3      <= '0;
         grant_id <= '0;
      end else if (xfer) begin
         ptr      <= grant_idx;
         we3      <= (sel_addr != '0);
         wa3      <= sel_addr;
         wd3      <= sel_data;
         grant_id <= grant_idx;
      end else begin
         we3      <= 1'b0;
      end
   end

   a_ready_onehot: assert property (
      @(posedge clk) disable iff (reset) $onehot0(req_ready));

   a_stall_no_ready: assert property (
      @(posedge clk) disable iff (reset) !enable |-> (req_ready == '0));

   a_ready_has_valid: assert property (
      @(posedge clk) disable iff (reset) ((req_ready & ~req_valid) == '0));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios
// plus randomized requesters checked against a round-robin model.
module tb_regfile_write_arbiter;

   localparam int N  = 2;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            we3;
   logic [AW-1:0]   wa3;
   logic [DW-1:0]   wd3;
   logic [0:0]      grant_id;

   regfile_write_arbiter #(
      .NUM_REQ(N),
      .ADDR_W(AW),
      .DATA_W(DW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .req_valid(req_valid),
      .req_addr(req_addr),
      .req_data(req_data),
      .req_ready(req_ready),
      .we3(we3),
      .wa3(wa3),
      .wd3(wd3),
      .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      int            id;
   } exp_t;

   exp_t         out_q[$];
   logic [N-1:0] rdy_q[$];
   int           checks = 0;
   int           errors = 0;
   int           ptr_m = N - 1;
   logic         pending = 1'b0;
   logic [DW-1:0] exp_rf [32] = '{default: '0};
   logic [DW-1:0] rf     [32] = '{default: '0};

   // Register file driven only by the arbiter's write port.
   always @(posedge clk) begin
      if (we3) rf[wa3] <= wd3;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Present one cycle of requests and predict the arbiter's response.
   task automatic drive(input logic en, input logic [N-1:0] v,
                        input logic [N*AW-1:0] a,
                        input logic [N*DW-1:0] d, output int g);
      logic [N-1:0] r;
      exp_t e;
      enable    = en;
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      g = -1;
      r = '0;
      if (en) begin
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (ptr_m + k) % N;
            if (g < 0 && v[i]) g = i;
         end
      end
      if (g >= 0) begin
         r[g] = 1'b1;
         e.wa = a[g*AW +: AW];
         e.wd = d[g*DW +: DW];
         e.we = (e.wa != '0);
         e.id = g;
         out_q.push_back(e);
         ptr_m = g;
      end
      rdy_q.push_back(r);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      int g;
      for (int i = 0; i < n; i++) drive(1'b1, '0, '0, '0, g);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      enable    = 1'b0;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      ptr_m = N - 1;
   endtask

   // Monitor: compare ready each cycle and the write stage one cycle later.
   always @(negedge clk) begin
      exp_t e;
      logic [N-1:0] r;
      if (reset) begin
         check("rst_we3", 32'(we3), 0);
         check("rst_wa3", 32'(wa3), 0);
         check("rst_wd3", wd3, 0);
         check("rst_grant_id", 32'(grant_id), 0);
         check("rst_ready", 32'(req_ready), 0);
         pending = 1'b0;
         out_q.delete();
         rdy_q.delete();
      end else begin
         if (pending) begin
            if (out_q.size() == 0) begin
               errors++;
               $display("FAIL out_queue actual=empty required=entry");
            end else begin
               e = out_q.pop_front();
               check("we3", 32'(we3), 32'(e.we));
               check("wa3", 32'(wa3), 32'(e.wa));
               check("wd3", wd3, e.wd);
               check("grant_id", 32'(grant_id), e.id);
               if (e.we) exp_rf[e.wa] = e.wd;
            end
         end else begin
            check("idle_we3", 32'(we3), 0);
         end
         pending = 1'b0;
         if (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            check("req_ready", 32'(req_ready), 32'(r));
            pending = (r != '0);
         end
      end
   end

   logic          pend [N];
   logic [AW-1:0] pa [N];
   logic [DW-1:0] pd [N];
   logic [N-1:0]    tv;
   logic [N*AW-1:0] ta;
   logic [N*DW-1:0] td;
   logic [DW-1:0]   old9;
   int              g;

   initial begin
      do_reset();

      // Single write from requester 0.
      drive(1'b1, 2'b01, {5'd0, 5'd3}, {32'd0, 32'hA0}, g);
      idle(1);
      check("t1_rf3", rf[3], 32'hA0);

      // Both requesters valid continuously: alternating grants.
      for (int i = 0; i < 8; i++)
         drive(1'b1, 2'b11, {5'd2, 5'd1}, {32'h2222, 32'h1111}, g);
      idle(1);

      // x0 write is acknowledged but never reaches the regfile.
      drive(1'b1, 2'b10, {5'd0, 5'd0}, {32'hFFFF_FFFF, 32'd0}, g);
      idle(1);
      check("t3_rf0", rf[0], 32'd0);

      // Same destination from both: grant order decides the final value.
      do_reset();
      drive(1'b1, 2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, g);
      drive(1'b1, 2'b10, {5'd7, 5'd7}, {32'h22, 32'h11}, g);
      idle(2);
      check("t4_rf7", rf[7], 32'h22);

      // Stall holds everything, then arbitration resumes.
      for (int i = 0; i < 3; i++)
         drive(1'b0, 2'b11, {5'd5, 5'd4}, {32'h55, 32'h44}, g);
      drive(1'b1, 2'b11, {5'd5, 5'd4}, {32'h55, 32'h44}, g);
      drive(1'b1, 2'b11, {5'd5, 5'd4}, {32'h56, 32'h45}, g);
      idle(1);

      // Reset right after an accept drops the pending write.
      old9 = rf[9];
      drive(1'b1, 2'b01, {5'd0, 5'd9}, {32'd0, 32'h9999}, g);
      reset = 1'b1;
      do_reset();
      idle(2);
      check("t6_rf9", rf[9], old9);

      // Every non-zero register through alternating requesters.
      for (int i = 1; i < 32; i++) begin
         tv = '0;
         tv[i % 2] = 1'b1;
         drive(1'b1, tv, {5'(i), 5'(i)},
               {32'(i) * 32'h0004_0101, 32'(i) * 32'h0004_0101}, g);
      end
      idle(2);
      for (int j = 0; j < 32; j++) check("loop_rf", rf[j], exp_rf[j]);

      // Randomized requesters that hold until accepted or withdraw.
      for (int r = 0; r < N; r++) pend[r] = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < N; r++) begin
            if (pend[r] && $urandom_range(0, 15) == 0) pend[r] = 1'b0;
            if (!pend[r] && $urandom_range(0, 1) == 1) begin
               pend[r] = 1'b1;
               pa[r] = ($urandom_range(0, 7) == 0) ?
                       5'd0 : 5'($urandom_range(1, 31));
               pd[r] = $urandom;
            end
            tv[r] = pend[r];
            ta[r*AW +: AW] = pa[r];
            td[r*DW +: DW] = pd[r];
         end
         drive($urandom_range(0, 9) != 0, tv, ta, td, g);
         if (g >= 0) pend[g] = 1'b0;
      end
      idle(3);
      for (int j = 0; j < 32; j++) check("final_rf", rf[j], exp_rf[j]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
